// File: rtl/clk_mux_pkg.sv
// Shared types and helpers for the clock-mux failover controller.
package clk_mux_pkg;

  // Controller phases: waiting for the mux output to settle, normal
  // operation, or parked because no candidate clock is healthy.
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_NOCLK  = 2'd2
  } mux_state_e;

  // Widest candidate set the priority encoder handles.
  localparam int MAX_CLK = 8;

  // Index of the lowest set bit (highest priority); 0 when vec is empty,
  // so callers must qualify the result with their own "any set" flag.
  function automatic logic [2:0] lowest_set(input logic [MAX_CLK-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = MAX_CLK - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/clk_stop_debounce.sv
// Single-bit persistence filter for one clock-stop flag: the filtered value
// only follows the raw flag after HOLDOFF_CYCLES consecutive differing samples.
module clk_stop_debounce #(
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic clk_ref,
  input  logic reset_in,
  input  logic stopped,
  output logic filt,
  output logic filt_nxt
);

  localparam int CW = $clog2(HOLDOFF_CYCLES + 1);

  logic          filt_r;
  logic          filt_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;

  // Count consecutive disagreeing samples; flip the filter on the last one.
  always_comb begin
    filt_nxt_s = filt_r;
    cnt_nxt_s  = cnt_r;
    if (stopped == filt_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CW'(HOLDOFF_CYCLES - 1)) begin
      filt_nxt_s = ~filt_r;
      cnt_nxt_s  = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Filter state register with synchronous reset.
  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      filt_r <= 1'b0;
      cnt_r  <= '0;
    end else begin
      filt_r <= filt_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign filt     = filt_r;
  assign filt_nxt = filt_nxt_s;

endmodule

// File: rtl/clk_mux_ctrl.sv
// Clock-mux failover controller: debounces per-clock stop flags, selects the
// highest-priority healthy clock, sequences switches through a settle window,
// optionally reverts to a recovered higher-priority clock, honours a force.
module clk_mux_ctrl
  import clk_mux_pkg::*;
#(
  parameter int NUM_CLK        = 2,
  parameter int SEL_WIDTH      = (NUM_CLK > 2) ? $clog2(NUM_CLK) : 1,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 1024,
  parameter bit AUTO_REVERT    = 1'b1,
  parameter int REVERT_CYCLES  = 65536,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk_ref,
  input  logic                   reset_in,
  input  logic [NUM_CLK-1:0]     stopped,
  input  logic                   force_en,
  input  logic [SEL_WIDTH-1:0]   force_sel,
  output logic [SEL_WIDTH-1:0]   sel,
  output logic                   switching,
  output logic                   all_stopped,
  output logic                   clk_ok,
  output logic [COUNT_WIDTH-1:0] switch_count
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int REV_W    = $clog2(REVERT_CYCLES + 1);
  // Filter vectors are padded to the full select range so any select value
  // indexes them without a width mismatch.
  localparam int PAD_W    = 2 ** SEL_WIDTH;

  logic [NUM_CLK-1:0]     filt_s;
  logic [NUM_CLK-1:0]     filt_nxt_s;
  logic [NUM_CLK-1:0]     healthy_s;
  logic [PAD_W-1:0]       filt_pad_s;
  logic [PAD_W-1:0]       filt_nxt_pad_s;
  logic                   none_s;
  logic                   force_valid_s;
  logic                   do_switch_s;
  logic [SEL_WIDTH-1:0]   best_s;
  logic [SEL_WIDTH-1:0]   target_s;
  logic [SEL_WIDTH-1:0]   sel_r;
  logic [SEL_WIDTH-1:0]   sel_nxt_s;
  mux_state_e             state_r;
  mux_state_e             state_nxt_s;
  logic [SETTLE_W-1:0]    settle_r;
  logic [SETTLE_W-1:0]    settle_nxt_s;
  logic [REV_W-1:0]       rev_r;
  logic [REV_W-1:0]       rev_nxt_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [COUNT_WIDTH-1:0] count_nxt_s;
  logic                   switching_r;
  logic                   all_stopped_r;
  logic                   clk_ok_r;

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_deb
    clk_stop_debounce #(
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_deb (
      .clk_ref  (clk_ref),
      .reset_in (reset_in),
      .stopped  (stopped[g]),
      .filt     (filt_s[g]),
      .filt_nxt (filt_nxt_s[g])
    );
  end

  assign healthy_s      = ~filt_s;
  assign none_s         = ~|healthy_s;
  assign best_s         = SEL_WIDTH'(lowest_set(MAX_CLK'(healthy_s)));
  assign filt_pad_s     = PAD_W'(filt_s);
  assign filt_nxt_pad_s = PAD_W'(filt_nxt_s);
  // Out-of-range force selects behave as if the force were released.
  assign force_valid_s  = force_en && (32'(force_sel) < 32'(NUM_CLK));

  // Next-state decision plus switch commit (select, counter, settle reload).
  always_comb begin
    state_nxt_s  = state_r;
    settle_nxt_s = settle_r;
    rev_nxt_s    = rev_r;
    sel_nxt_s    = sel_r;
    count_nxt_s  = count_r;
    do_switch_s  = 1'b0;
    target_s     = sel_r;
    case (state_r)
      ST_SETTLE: begin
        rev_nxt_s = '0;
        if (settle_r <= SETTLE_W'(1)) begin
          state_nxt_s  = ST_RUN;
          settle_nxt_s = '0;
        end else begin
          settle_nxt_s = settle_r - SETTLE_W'(1);
        end
      end
      ST_RUN: begin
        if (force_valid_s && (force_sel != sel_r)) begin
          do_switch_s = 1'b1;
          target_s    = force_sel;
        end else if (force_valid_s) begin
          rev_nxt_s = '0;
        end else if (filt_pad_s[sel_r]) begin
          if (none_s) begin
            state_nxt_s = ST_NOCLK;
            rev_nxt_s   = '0;
          end else begin
            do_switch_s = 1'b1;
            target_s    = best_s;
          end
        end else if (AUTO_REVERT && (best_s < sel_r)) begin
          if (rev_r == REV_W'(REVERT_CYCLES - 1)) begin
            do_switch_s = 1'b1;
            target_s    = best_s;
          end else begin
            rev_nxt_s = rev_r + REV_W'(1);
          end
        end else begin
          rev_nxt_s = '0;
        end
      end
      ST_NOCLK: begin
        rev_nxt_s = '0;
        if (force_valid_s && (force_sel != sel_r)) begin
          do_switch_s = 1'b1;
          target_s    = force_sel;
        end else if (!none_s) begin
          do_switch_s = 1'b1;
          target_s    = best_s;
        end else begin
          state_nxt_s = ST_NOCLK;
        end
      end
      default: begin
        state_nxt_s  = ST_SETTLE;
        settle_nxt_s = SETTLE_W'(SETTLE_CYCLES);
        rev_nxt_s    = '0;
      end
    endcase
    // Leaving NOCLK onto the clock already selected still re-settles, but
    // only real select changes are counted.
    if (do_switch_s) begin
      sel_nxt_s    = target_s;
      state_nxt_s  = ST_SETTLE;
      settle_nxt_s = SETTLE_W'(SETTLE_CYCLES);
      rev_nxt_s    = '0;
      if ((target_s != sel_r) && (count_r != '1)) begin
        count_nxt_s = count_r + COUNT_WIDTH'(1);
      end else begin
        count_nxt_s = count_r;
      end
    end else begin
      sel_nxt_s = sel_r;
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_ref) begin
    if (reset_in) begin
      state_r       <= ST_SETTLE;
      settle_r      <= SETTLE_W'(SETTLE_CYCLES);
      rev_r         <= '0;
      sel_r         <= '0;
      count_r       <= '0;
      switching_r   <= 1'b1;
      all_stopped_r <= 1'b0;
      clk_ok_r      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      settle_r      <= settle_nxt_s;
      rev_r         <= rev_nxt_s;
      sel_r         <= sel_nxt_s;
      count_r       <= count_nxt_s;
      switching_r   <= (state_nxt_s == ST_SETTLE);
      all_stopped_r <= (state_nxt_s == ST_NOCLK);
      clk_ok_r      <= (state_nxt_s == ST_RUN) && !filt_nxt_pad_s[sel_nxt_s];
    end
  end

  assign sel          = sel_r;
  assign switching    = switching_r;
  assign all_stopped  = all_stopped_r;
  assign clk_ok       = clk_ok_r;
  assign switch_count = count_r;

endmodule
